maquina_principal: RTL and testbench
====================================

MAQUINA_PRINCIPAL -- requirements
Module: maquina_principal

Interface
REQ-001 Parameter PRICE0, default 3, price of drink 0 in credit units.
REQ-002 Parameter PRICE1, default 4, price of drink 1 in credit units.
REQ-003 Parameter PRICE2, default 5, price of drink 2 in credit units.
REQ-004 Parameter PRICE3, default 6, price of drink 3 in credit units.
REQ-005 Parameter ERR_CYCLES, default 4, number of cycles ERRO is held high.
REQ-006 Parameter TIMEOUT, default 1000, maximum cycles to wait for BEBIDAS.
REQ-007 clk  in  1  single clock; all state changes on the rising edge.
REQ-008 reset_n  in  1  reset; asynchronous, active-low.
REQ-009 coin  in  2  coin value: 00=0, 01=1, 10=2, 11=5 units; sampled only when coin_valid=1.
REQ-010 coin_valid  in  1  one-cycle coin-inserted strobe.
REQ-011 drink_sel  in  2  selected drink index; sampled on confirm.
REQ-012 confirm  in  1  one-cycle purchase request.
REQ-013 cancel  in  1  one-cycle abort/refund request.
REQ-014 BEBIDAS  in  1  dispenser done acknowledge.
REQ-015 ENTER  out  1  dispense request to dispenser.
REQ-016 ERRO  out  1  payment error indication.
REQ-017 change_pulse  out  1  one credit unit returned per high cycle.
REQ-018 coin_reject  out  1  one-cycle pulse; the coin sampled that cycle was not credited.
REQ-019 credit  out  5  current credit, 0..31.
REQ-020 busy  out  1  high in REQUEST, ERROR and CHANGE.

Function
REQ-021 The FSM SHALL have exactly these states: IDLE, COLLECT, REQUEST, ERROR, CHANGE.
REQ-022 In IDLE/COLLECT, an accepted coin SHALL add its value to credit on the next edge and force COLLECT.
REQ-023 A coin that would take credit above 31, or a coin arriving in REQUEST/ERROR/CHANGE, SHALL be discarded; coin_reject SHALL pulse the following cycle.
REQ-024 In COLLECT, confirm with registered credit >= price(drink_sel) SHALL latch drink_sel and enter REQUEST.
REQ-025 The credit comparison SHALL use the credit before any coin sampled in the same cycle; that coin is still credited.
REQ-026 In COLLECT, confirm with credit < price SHALL enter ERROR; credit is kept.
REQ-027 In COLLECT, cancel SHALL enter CHANGE; cancel SHALL take priority over a simultaneous confirm.
REQ-028 In IDLE, confirm SHALL enter ERROR; cancel SHALL be ignored.
REQ-029 ENTER SHALL be registered and high for every cycle in REQUEST, then low within one cycle of leaving REQUEST.
REQ-030 In REQUEST, BEBIDAS=1 SHALL subtract the latched price from credit; the FSM SHALL go to CHANGE if the remainder is >0, else IDLE.
REQ-031 In REQUEST, cancel SHALL be ignored.
REQ-032 If BEBIDAS is not seen within TIMEOUT cycles of entering REQUEST, the FSM SHALL enter ERROR with credit unchanged; the ERROR exit then goes to CHANGE, refunding all credit.
REQ-033 ERRO SHALL be high exactly ERR_CYCLES cycles.
REQ-034 On exit from ERROR, the FSM SHALL go to COLLECT if credit>0, else IDLE; the timeout exit is governed by REQ-032.
REQ-035 In CHANGE, change_pulse SHALL alternate high one cycle and low one cycle.
REQ-036 Credit SHALL decrement by 1 on each change_pulse high cycle.
REQ-037 When credit reaches 0 in CHANGE, the FSM SHALL enter IDLE with change_pulse low.
REQ-038 credit SHALL be a registered output, never wrap, and never go negative.
REQ-039 All outputs SHALL be registered, with no combinational path from inputs.

Reset
REQ-040 reset_n=0 SHALL immediately force IDLE, credit=0, and ENTER=ERRO=change_pulse=coin_reject=busy=0, independent of clk.
REQ-041 A reset during REQUEST or CHANGE SHALL drop ENTER/change_pulse at once; lost credit SHALL NOT be restored.
REQ-042 The first state transition SHALL occur on the first rising edge after reset_n rises.

Verification
- Coins 2,2 (credit 4), drink_sel=1, confirm -> ENTER high until BEBIDAS; credit 0; IDLE; no change_pulse.
- Coins 5,2 (credit 7), drink_sel=0, confirm, BEBIDAS after 10 cycles -> credit 4, then 4 change_pulses, then IDLE.
- Credit 2, drink_sel=3, confirm -> ERRO high 4 cycles, credit 2, COLLECT; ENTER never high.
- Credit 30, coin=10 -> coin_reject pulse, credit 30; coin during REQUEST -> coin_reject.
- REQUEST with no BEBIDAS for 1000 cycles -> ERRO 4 cycles, then full refund pulses, IDLE.
- Confirm+cancel same cycle with credit 3 -> 3 change_pulses; reset_n low mid-CHANGE -> all outputs 0 asynchronously, credit 0.

Source files
------------

// File: rtl/maquina_principal.sv
// Drink vending controller: collects coins, checks the price of the selected drink,
// drives the dispenser handshake and returns change one credit unit per pulse.
module maquina_principal #(
    parameter int PRICE0     = 3,
    parameter int PRICE1     = 4,
    parameter int PRICE2     = 5,
    parameter int PRICE3     = 6,
    parameter int ERR_CYCLES = 4,
    parameter int TIMEOUT    = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] coin,
    input  logic       coin_valid,
    input  logic [1:0] drink_sel,
    input  logic       confirm,
    input  logic       cancel,
    input  logic       BEBIDAS,
    output logic       ENTER,
    output logic       ERRO,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic [4:0] credit,
    output logic       busy
);

    localparam int ECW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, COLLECT, REQUEST, ERROR, CHANGE} state_t;

    state_t         state_reg, state_next;
    logic [4:0]     credit_reg, credit_next;
    logic [4:0]     price_reg, price_next;
    logic [ECW-1:0] err_cnt_reg, err_cnt_next;
    logic [TCW-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic           tmo_flag_reg, tmo_flag_next;
    logic           pulse_reg, pulse_next;
    logic           reject_reg, reject_next;
    logic           enter_reg, erro_reg, busy_reg;

    logic [5:0]     coin_val;
    logic [5:0]     coin_sum;
    logic           coin_ok;
    logic [4:0]     price_sel;
    logic [4:0]     remain;

    always_comb begin
        unique case (coin)
            2'b00:   coin_val = 6'd0;
            2'b01:   coin_val = 6'd1;
            2'b10:   coin_val = 6'd2;
            default: coin_val = 6'd5;
        endcase
        unique case (drink_sel)
            2'd0:    price_sel = 5'(PRICE0);
            2'd1:    price_sel = 5'(PRICE1);
            2'd2:    price_sel = 5'(PRICE2);
            default: price_sel = 5'(PRICE3);
        endcase
    end

    assign coin_sum = {1'b0, credit_reg} + coin_val;
    // Coins only count while shopping and only if the credit cannot overflow.
    assign coin_ok  = coin_valid && (state_reg == IDLE || state_reg == COLLECT)
                      && (coin_sum <= 6'd31);
    assign remain   = (credit_reg >= price_reg) ? (credit_reg - price_reg) : 5'd0;

    always_comb begin
        state_next    = state_reg;
        credit_next   = credit_reg;
        price_next    = price_reg;
        err_cnt_next  = err_cnt_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        tmo_flag_next = tmo_flag_reg;
        pulse_next    = 1'b0;
        reject_next   = coin_valid && !coin_ok;

        if (coin_ok) begin
            credit_next = coin_sum[4:0];
        end

        unique case (state_reg)
            IDLE: begin
                if (confirm) begin
                    state_next    = ERROR;
                    err_cnt_next  = '0;
                    tmo_flag_next = 1'b0;
                end else if (coin_ok) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    state_next = CHANGE;
                end else if (confirm) begin
                    // Compare against the credit held before any same-cycle coin.
                    if (credit_reg >= price_sel) begin
                        state_next   = REQUEST;
                        price_next   = price_sel;
                        tmo_cnt_next = '0;
                    end else begin
                        state_next    = ERROR;
                        err_cnt_next  = '0;
                        tmo_flag_next = 1'b0;
                    end
                end
            end
            REQUEST: begin
                if (BEBIDAS) begin
                    credit_next = remain;
                    state_next  = (remain != 5'd0) ? CHANGE : IDLE;
                end else if (tmo_cnt_reg == TCW'(TIMEOUT - 1)) begin
                    state_next    = ERROR;
                    err_cnt_next  = '0;
                    tmo_flag_next = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            ERROR: begin
                if (err_cnt_reg == ECW'(ERR_CYCLES - 1)) begin
                    if (tmo_flag_reg) begin
                        state_next = CHANGE;
                    end else if (credit_reg != 5'd0) begin
                        state_next = COLLECT;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    err_cnt_next = err_cnt_reg + 1'b1;
                end
            end
            CHANGE: begin
                // Credit drops on the same edge that raises the pulse.
                if (pulse_reg) begin
                    if (credit_reg == 5'd0) begin
                        state_next = IDLE;
                    end
                end else if (credit_reg != 5'd0) begin
                    pulse_next  = 1'b1;
                    credit_next = credit_reg - 5'd1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            credit_reg   <= 5'd0;
            price_reg    <= 5'd0;
            err_cnt_reg  <= '0;
            tmo_cnt_reg  <= '0;
            tmo_flag_reg <= 1'b0;
            pulse_reg    <= 1'b0;
            reject_reg   <= 1'b0;
            enter_reg    <= 1'b0;
            erro_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            credit_reg   <= credit_next;
            price_reg    <= price_next;
            err_cnt_reg  <= err_cnt_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            tmo_flag_reg <= tmo_flag_next;
            pulse_reg    <= pulse_next;
            reject_reg   <= reject_next;
            enter_reg    <= (state_next == REQUEST);
            erro_reg     <= (state_next == ERROR);
            busy_reg     <= (state_next == REQUEST) || (state_next == ERROR)
                            || (state_next == CHANGE);
        end
    end

    assign ENTER        = enter_reg;
    assign ERRO         = erro_reg;
    assign change_pulse = pulse_reg;
    assign coin_reject  = reject_reg;
    assign credit       = credit_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_maquina_principal.sv
// Directed scoreboard bench for maquina_principal: expectations are queued as
// stimulus is applied and popped when the corresponding output is sampled.
module tb_maquina_principal;

    logic       clk;
    logic       reset_n;
    logic [1:0] coin;
    logic       coin_valid;
    logic [1:0] drink_sel;
    logic       confirm;
    logic       cancel;
    logic       BEBIDAS;
    logic       ENTER;
    logic       ERRO;
    logic       change_pulse;
    logic       coin_reject;
    logic [4:0] credit;
    logic       busy;

    maquina_principal dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .coin        (coin),
        .coin_valid  (coin_valid),
        .drink_sel   (drink_sel),
        .confirm     (confirm),
        .cancel      (cancel),
        .BEBIDAS     (BEBIDAS),
        .ENTER       (ENTER),
        .ERRO        (ERRO),
        .change_pulse(change_pulse),
        .coin_reject (coin_reject),
        .credit      (credit),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got %0d with no queued expectation", obs);
        end else begin
            e = sb.pop_front();
            vectors++;
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: got %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] c);
        coin       = c;
        coin_valid = 1'b1;
        step();
        coin_valid = 1'b0;
        coin       = 2'b00;
    endtask

    task automatic buy(input logic [1:0] sel);
        drink_sel = sel;
        confirm   = 1'b1;
        step();
        confirm   = 1'b0;
    endtask

    // Counts change pulses until the machine leaves its busy states.
    task automatic drain(output int n, output int bad);
        logic prev;
        n = 0;
        bad = 0;
        prev = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (change_pulse) begin
                n++;
                if (prev) bad++;
            end
            prev = change_pulse;
            if (!busy) break;
            step();
        end
    endtask

    task automatic count_erro(output int n, output int en);
        n = 0;
        en = 0;
        for (int i = 0; i < 50; i++) begin
            if (!ERRO) break;
            n++;
            if (ENTER) en++;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int n, bad, en;

    initial begin
        reset_n    = 1'b0;
        coin       = 2'b00;
        coin_valid = 1'b0;
        drink_sel  = 2'd0;
        confirm    = 1'b0;
        cancel     = 1'b0;
        BEBIDAS    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push("rst_enter", 0);  check(ENTER);
        push("rst_erro", 0);   check(ERRO);
        push("rst_pulse", 0);  check(change_pulse);
        push("rst_reject", 0); check(coin_reject);
        push("rst_credit", 0); check(credit);
        push("rst_busy", 0);   check(busy);
        reset_n = 1'b1;
        step();

        // IDLE: cancel ignored, confirm gives an error burst
        cancel = 1'b1;
        push("idle_cancel_busy", 0);
        step();
        cancel = 1'b0;
        check(busy);
        push("idle_confirm_erro", 1);
        buy(2'd0);
        check(ERRO);
        push("idle_erro_len", 4);
        push("idle_erro_after_busy", 0);
        count_erro(n, en);
        check(n);
        check(busy);

        // Exact payment: 2+2 for drink 1
        push("t1_credit_a", 2); put_coin(2'b10); check(credit);
        push("t1_credit_b", 4); put_coin(2'b10); check(credit);
        push("t1_enter", 1); buy(2'd1); check(ENTER);
        repeat (3) step();
        push("t1_enter_hold", 1); check(ENTER);
        BEBIDAS = 1'b1;
        push("t1_enter_off", 0);
        push("t1_credit", 0);
        push("t1_busy", 0);
        step();
        BEBIDAS = 1'b0;
        check(ENTER); check(credit); check(busy);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (change_pulse) n++;
            step();
        end
        push("t1_no_change", 0); check(n);

        // Overpayment: 5+2 for drink 0, then 4 units of change
        put_coin(2'b11);
        push("t2_credit", 7); put_coin(2'b10); check(credit);
        push("t2_enter", 1); buy(2'd0); check(ENTER);
        repeat (9) step();
        BEBIDAS = 1'b1;
        push("t2_credit_after", 4);
        push("t2_enter_off", 0);
        push("t2_busy", 1);
        step();
        BEBIDAS = 1'b0;
        check(credit); check(ENTER); check(busy);
        push("t2_pulses", 4); push("t2_adjacent", 0); push("t2_final_credit", 0);
        drain(n, bad);
        check(n); check(bad); check(credit);

        // Insufficient credit: 2 units for drink 3
        push("t3_credit", 2); put_coin(2'b10); check(credit);
        push("t3_erro", 1); push("t3_enter", 0);
        buy(2'd3);
        check(ERRO); check(ENTER);
        push("t3_erro_len", 4); push("t3_enter_in_err", 0);
        push("t3_credit_kept", 2); push("t3_collect_busy", 0);
        count_erro(n, en);
        check(n); check(en); check(credit); check(busy);
        cancel = 1'b1;
        push("t3_cancel_busy", 1);
        step();
        cancel = 1'b0;
        check(busy);
        push("t3_refund", 2);
        drain(n, bad);
        check(n);

        // Overflow reject and coin during REQUEST
        repeat (5) put_coin(2'b11);
        push("t4_credit30", 30); put_coin(2'b11); check(credit);
        push("t4_reject", 1); push("t4_credit_kept", 30);
        put_coin(2'b10);
        check(coin_reject); check(credit);
        push("t4_reject_clear", 0); step(); check(coin_reject);
        push("t4_enter", 1); buy(2'd3); check(ENTER);
        push("t4_req_reject", 1); push("t4_req_credit", 30);
        put_coin(2'b01);
        check(coin_reject); check(credit);
        BEBIDAS = 1'b1;
        push("t4_credit_after", 24);
        step();
        BEBIDAS = 1'b0;
        check(credit);
        push("t4_pulses", 24); push("t4_adjacent", 0);
        drain(n, bad);
        check(n); check(bad);

        // Dispenser timeout: full refund after the error burst
        put_coin(2'b11);
        push("t5_enter", 1); buy(2'd2); check(ENTER);
        n = 0;
        for (int i = 0; i < 1100; i++) begin
            if (!ENTER) break;
            n++;
            step();
        end
        push("t5_enter_cycles", 1000); check(n);
        push("t5_erro", 1); check(ERRO);
        push("t5_credit", 5); check(credit);
        push("t5_erro_len", 4);
        count_erro(n, en);
        check(n);
        push("t5_refund", 5); push("t5_final_credit", 0); push("t5_idle", 0);
        drain(n, bad);
        check(n); check(credit); check(busy);

        // Cancel beats confirm
        put_coin(2'b10);
        push("t6_credit", 3); put_coin(2'b01); check(credit);
        drink_sel = 2'd0;
        confirm   = 1'b1;
        cancel    = 1'b1;
        push("t6_busy", 1); push("t6_enter", 0);
        step();
        confirm = 1'b0;
        cancel  = 1'b0;
        check(busy); check(ENTER);
        push("t6_refund", 3);
        drain(n, bad);
        check(n);

        // Asynchronous reset in the middle of CHANGE
        put_coin(2'b11);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        step();
        push("t7_pulse", 1); check(change_pulse);
        #2;
        reset_n = 1'b0;
        #1;
        push("t7_pulse_rst", 0);  check(change_pulse);
        push("t7_credit_rst", 0); check(credit);
        push("t7_busy_rst", 0);   check(busy);
        push("t7_enter_rst", 0);  check(ENTER);
        push("t7_erro_rst", 0);   check(ERRO);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        push("t7_credit_after", 0); check(credit);
        push("t7_coin_after", 1); put_coin(2'b01); check(credit);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
